// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART transmit sequencer.
package uart_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned MAX_BYTES = 8;
    localparam int unsigned LEN_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_ACK,
        WAIT_DONE,
        GAP
    } state_t;

    // A zero length still sends one byte; anything beyond the payload is cut to the payload size.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input int unsigned      max_b);
        logic [LEN_W-1:0] r;
        r = len;
        if (len == '0) begin
            r = LEN_W'(1);
        end else if (32'(len) > max_b) begin
            r = LEN_W'(max_b);
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-high clear.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_tx_sequencer.sv
// Round-robin two-requester message scheduler feeding a baud-domain UART
// transmitter one byte at a time over a level start/busy handshake.
module uart_tx_sequencer #(
    parameter int unsigned MAX_BYTES   = uart_pkg::MAX_BYTES,
    parameter int unsigned GAP_CYCLES  = 16,
    parameter int unsigned ACK_TIMEOUT = 400000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [1:0]                         req,
    input  logic [uart_pkg::BYTE_W*MAX_BYTES-1:0] payload0,
    input  logic [uart_pkg::BYTE_W*MAX_BYTES-1:0] payload1,
    input  logic [3:0]                         len0,
    input  logic [3:0]                         len1,
    output logic [1:0]                         done,
    output logic [1:0]                         abort,
    output logic [1:0]                         gnt,
    output logic [uart_pkg::BYTE_W-1:0]        tx_data,
    output logic                               tx_start,
    input  logic                               tx_busy
);

    import uart_pkg::*;

    localparam int unsigned PAY_W   = BYTE_W * MAX_BYTES;
    localparam int unsigned CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    state_t              state_q, state_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          done_q, done_d;
    logic [1:0]          abort_q, abort_d;
    logic                rr_q, rr_d;
    logic [PAY_W-1:0]    pay_q, pay_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BYTE_W-1:0]   txd_q, txd_d;
    logic                txs_q, txs_d;
    logic                bsy, bsy_q;
    logic                bsy_rise, bsy_fall;
    logic                pick1;
    logic [LEN_W-1:0]    idx_inc;
    logic [BYTE_W-1:0]   byte_sel;

    sync_2ff u_busy_sync (
        .clk (clk),
        .rst (rst),
        .d_i (tx_busy),
        .q_o (bsy)
    );

    assign bsy_rise = bsy & ~bsy_q;
    assign bsy_fall = ~bsy & bsy_q;

    always_comb begin
        byte_sel = '0;
        for (int i = 0; i < int'(MAX_BYTES); i++) begin
            if (idx_q == LEN_W'(i)) begin
                byte_sel = pay_q[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        abort_d = '0;
        rr_d    = rr_q;
        pay_d   = pay_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        txd_d   = txd_q;
        txs_d   = txs_q;
        pick1   = req[1] & (~req[0] | rr_q);
        idx_inc = idx_q + LEN_W'(1);

        case (state_q)
            IDLE: begin
                // Hold off one extra cycle after a completion so gnt is seen low for two cycles.
                if ((|req) && !(|done_q) && !(|abort_q)) begin
                    gnt_d   = pick1 ? 2'b10 : 2'b01;
                    rr_d    = ~pick1;
                    pay_d   = pick1 ? payload1 : payload0;
                    len_d   = clamp_len(pick1 ? len1 : len0, MAX_BYTES);
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                txd_d   = byte_sel;
                txs_d   = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bsy_rise) begin
                    txs_d   = 1'b0;
                    state_d = WAIT_DONE;
                end else if (cnt_q == ACK_LAST) begin
                    txs_d   = 1'b0;
                    abort_d = gnt_q;
                    gnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (bsy_fall) begin
                    idx_d = idx_inc;
                    cnt_d = '0;
                    if (idx_inc == len_q) begin
                        done_d  = gnt_q;
                        gnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (GAP_CYCLES == 0 || cnt_q == GAP_LAST) begin
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            abort_q <= '0;
            rr_q    <= 1'b0;
            pay_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            txd_q   <= '0;
            txs_q   <= 1'b0;
            bsy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            rr_q    <= rr_d;
            pay_q   <= pay_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            txd_q   <= txd_d;
            txs_q   <= txs_d;
            bsy_q   <= bsy;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign abort    = abort_q;
    assign tx_data  = txd_q;
    assign tx_start = txs_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Self-checking bench: directed handshake/arbitration/timeout/reset cases plus
// randomized traffic checked against a message-level reference model.
module tb_uart_tx_sequencer;

    localparam int PER  = 10;
    localparam int GAP  = 5;
    localparam int TMO  = 50;
    localparam int NMSG = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [63:0] payload0, payload1;
    logic [3:0]  len0, len1;
    logic [1:0]  done, abort, gnt;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;

    always #(PER/2) clk = ~clk;

    uart_tx_sequencer #(.MAX_BYTES(8), .GAP_CYCLES(GAP), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .payload0(payload0), .payload1(payload1),
        .len0(len0), .len1(len1), .done(done), .abort(abort), .gnt(gnt),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] oh(input int w);
        if (w < 0) return 2'b00;
        return (w == 0) ? 2'b01 : 2'b10;
    endfunction

    // Transmitter model: acknowledges each start after a random delay, stays busy a while.
    typedef struct { logic [1:0] g; logic [7:0] d; int gap; } cap_t;
    cap_t   cap_q[$];
    cap_t   tm_c;
    bit     tx_en = 1'b1;
    int     tm_st = 0;
    int     tm_cnt = 0;
    longint fall_t = 0;

    always @(negedge clk) begin
        if (!tx_en) begin
            tx_busy = 1'b0;
            tm_st   = 0;
        end else begin
            case (tm_st)
                0: if (tx_start) begin
                    tm_c.g = gnt; tm_c.d = tx_data;
                    tm_c.gap = int'((longint'($time) - fall_t) / PER);
                    cap_q.push_back(tm_c);
                    tm_cnt = $urandom_range(0, 3);
                    tm_st  = 1;
                end
                1: if (tm_cnt == 0) begin
                    tx_busy = 1'b1; tm_cnt = $urandom_range(4, 8); tm_st = 2;
                end else tm_cnt--;
                default: if (tm_cnt == 0) begin
                    tx_busy = 1'b0; fall_t = longint'($time); tm_st = 0;
                end else tm_cnt--;
            endcase
        end
    end

    // Reference model: round-robin prediction and expected byte stream per message.
    int          mon_ptr = 0, owner = -1, exp_n = 0, cyc = 0, end_cyc = 0, mon_w = 0;
    logic [63:0] exp_pay = '0;
    logic [3:0]  mon_l;
    logic [1:0]  gnt_prev = '0;
    logic [7:0]  last_bytes[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            mon_ptr = 0; owner = -1; gnt_prev = '0; end_cyc = cyc;
            cap_q.delete();
        end else begin
            if (done != 0 || abort != 0) chk("pulse_exclusive", (done != 0) && (abort != 0), 0);
            if (gnt_prev == 0 && gnt != 0) begin
                mon_w = (req == 2'b11) ? mon_ptr : (req[1] ? 1 : 0);
                chk("grant_has_req", req != 0, 1);
                chk("grant_rr", gnt, oh(mon_w));
                chk("grant_spacing", (cyc - end_cyc) >= 2, 1);
                mon_ptr = 1 - mon_w;
                owner   = mon_w;
                exp_pay = mon_w ? payload1 : payload0;
                mon_l   = mon_w ? len1 : len0;
                exp_n   = (mon_l == 0) ? 1 : ((mon_l > 8) ? 8 : int'(mon_l));
            end
            if (gnt_prev != 0 && gnt != gnt_prev && done == 0 && abort == 0)
                chk("gnt_held", gnt, gnt_prev);
            if (done != 0) begin
                chk("done_owner", done, oh(owner));
                chk("done_gnt_low", gnt, 0);
                chk("msg_bytes", cap_q.size(), exp_n);
                last_bytes.delete();
                foreach (cap_q[i]) begin
                    if (i < 8) chk("byte_val", cap_q[i].d, exp_pay[8*i +: 8]);
                    chk("byte_owner", cap_q[i].g, oh(owner));
                    if (i > 0) chk("byte_gap", cap_q[i].gap, GAP + 4);
                    last_bytes.push_back(cap_q[i].d);
                end
                cap_q.delete(); end_cyc = cyc; owner = -1;
            end
            if (abort != 0) begin
                chk("abort_owner", abort, oh(owner));
                chk("abort_gnt_low", gnt, 0);
                cap_q.delete(); end_cyc = cyc; owner = -1;
            end
            gnt_prev = gnt;
        end
    end

    task automatic wait_end(input int limit, output logic [1:0] d, output logic [1:0] a, output int n);
        d = '0; a = '0; n = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (done != 0 || abort != 0) begin d = done; a = abort; n = i; return; end
        end
        checks++; errors++;
        $display("FAIL wait_end: no done/abort within %0d cycles", limit);
    endtask

    task automatic wait_start(input int limit, output int n);
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (tx_start) begin n = i; return; end
        end
        checks++; errors++;
        $display("FAIL wait_start: no tx_start within %0d cycles", limit);
    endtask

    typedef struct { logic [3:0] len; logic [63:0] pay; int exp_n; logic [7:0] exp_last; } vec_t;
    vec_t vecs[6];
    typedef struct { logic [63:0] pay; logic [3:0] len; } msg_t;
    msg_t rq0[$], rq1[$], m;

    task automatic present(input int r);
        if (r == 0) begin
            if (rq0.size() > 0) begin payload0 = rq0[0].pay; len0 = rq0[0].len; req[0] = 1'b1; end
            else req[0] = 1'b0;
        end else begin
            if (rq1.size() > 0) begin payload1 = rq1[0].pay; len1 = rq1[0].len; req[1] = 1'b1; end
            else req[1] = 1'b0;
        end
    endtask

    logic [1:0] d, a;
    int n, completed;
    bit seen;
    logic [1:0] arb_exp[4];

    initial begin
        vecs[0] = '{4'd0,  64'h0807060504030201, 1, 8'h01};
        vecs[1] = '{4'd12, 64'hF1E2D3C4B5A69788, 8, 8'hF1};
        vecs[2] = '{4'd8,  64'h0123456789ABCDEF, 8, 8'h01};
        vecs[3] = '{4'd3,  64'h0000000000CCBBAA, 3, 8'hCC};
        vecs[4] = '{4'd9,  64'h5A4B3C2D1E0F6070, 8, 8'h5A};
        vecs[5] = '{4'd1,  64'hFFFFFFFFFFFFFF3E, 1, 8'h3E};
        arb_exp = '{2'b01, 2'b10, 2'b01, 2'b10};

        rst = 1'b1; req = '0; payload0 = '0; payload1 = '0; len0 = '0; len1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 0); chk("rst_done", done, 0); chk("rst_abort", abort, 0);
        chk("rst_tx_start", tx_start, 0); chk("rst_tx_data", tx_data, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte: two-cycle latency, done three negedges after the busy fall.
        len0 = 4'd1; payload0 = 64'h85; req = 2'b01;
        @(negedge clk); chk("lat_gnt", gnt, 2'b01); chk("lat_start_low", tx_start, 0);
        @(negedge clk); chk("lat_start", tx_start, 1); chk("lat_data", tx_data, 8'h85);
        req = 2'b00;
        wait_end(500, d, a, n);
        chk("single_done", d, 2'b01);
        chk("single_done_delay", (longint'($time) - fall_t) / PER, 3);
        @(negedge clk); chk("single_done_pulse", done, 0); chk("single_gnt", gnt, 0);

        // Multi-byte order.
        len0 = 4'd4; payload0 = 64'h11563412; req = 2'b01;
        wait_end(1000, d, a, n); req = 2'b00;
        chk("multi_done", d, 2'b01);
        chk("multi_b0", last_bytes[0], 8'h12); chk("multi_b1", last_bytes[1], 8'h34);
        chk("multi_b2", last_bytes[2], 8'h56); chk("multi_b3", last_bytes[3], 8'h11);

        // Length clamp table on requester 1.
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            len1 = vecs[v].len; payload1 = vecs[v].pay; req = 2'b10;
            wait_end(2000, d, a, n); req = 2'b00;
            chk("clamp_done", d, 2'b10);
            chk("clamp_count", last_bytes.size(), vecs[v].exp_n);
            chk("clamp_last", last_bytes[last_bytes.size()-1], vecs[v].exp_last);
        end

        // Arbitration with both requesting continuously.
        @(negedge clk);
        payload0 = 64'hA0A1A2A3; len0 = 4'd2; payload1 = 64'hB0B1; len1 = 4'd1; req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_end(1000, d, a, n);
            chk("arb_order", d, arb_exp[k]);
        end
        req = 2'b00;

        // Acknowledge timeout.
        @(negedge clk);
        tx_en = 1'b0; len0 = 4'd3; payload0 = 64'h777777; req = 2'b01;
        wait_start(10, n); chk("tmo_latency", n, 2);
        wait_end(200, d, a, n); req = 2'b00;
        chk("tmo_abort", a, 2'b01); chk("tmo_no_done", d, 0); chk("tmo_cycles", n, TMO);
        chk("tmo_start_low", tx_start, 0); chk("tmo_gnt_low", gnt, 0);
        @(negedge clk); chk("tmo_pulse", abort, 0);
        tx_en = 1'b1;

        // Asynchronous reset while waiting for the first byte to finish.
        @(negedge clk);
        payload0 = 64'hA1B2C3D4E5F60718; len0 = 4'd4; req = 2'b01; seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_start) seen = 1'b1;
            else if (seen) break;
        end
        chk("rst_precond", {seen, tx_start, tx_data}, {2'b10, 8'h18});
        rst = 1'b1; tx_en = 1'b0; req = 2'b00;
        #1;
        chk("arst_gnt", gnt, 0); chk("arst_tx_start", tx_start, 0); chk("arst_tx_data", tx_data, 0);
        chk("arst_done", done, 0); chk("arst_abort", abort, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0; tx_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); chk("arst_no_pulse", {done, abort}, 0);
        end
        payload0 = 64'h4477; len0 = 4'd2; payload1 = 64'h99; len1 = 4'd1; req = 2'b11;
        @(negedge clk); chk("arst_prio", gnt, 2'b01);
        @(negedge clk); chk("arst_byte0", tx_data, 8'h77);
        wait_end(1000, d, a, n); chk("arst_done0", d, 2'b01);
        wait_end(1000, d, a, n); chk("arst_done1", d, 2'b10);
        req = 2'b00;

        // Randomized traffic with input scrambling while a message is in flight.
        for (int i = 0; i < NMSG; i++) begin
            m.pay = {$urandom, $urandom}; m.len = 4'($urandom_range(0, 15)); rq0.push_back(m);
            m.pay = {$urandom, $urandom}; m.len = 4'($urandom_range(0, 15)); rq1.push_back(m);
        end
        @(negedge clk);
        present(0); present(1);
        completed = 0;
        for (int c = 0; c < 30000 && completed < 2*NMSG; c++) begin
            @(negedge clk);
            if (abort != 0) chk("rand_no_abort", abort, 0);
            for (int r = 0; r < 2; r++) begin
                if (done[r] || abort[r]) begin
                    if (r == 0) void'(rq0.pop_front()); else void'(rq1.pop_front());
                    present(r);
                    completed++;
                end else if (gnt[r] && $urandom_range(0, 7) == 0) begin
                    if (r == 0) begin payload0 = {$urandom, $urandom}; len0 = 4'($urandom); end
                    else begin payload1 = {$urandom, $urandom}; len1 = 4'($urandom); end
                    req[r] = 1'($urandom_range(0, 1));
                end
            end
        end
        chk("rand_completed", completed, 2*NMSG);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_sequencer.md
Name: uart_tx_sequencer

Overview:
Two-requester message scheduler in front of the existing UART transmitter. Each requester presents a message of up to 8 bytes packed in a 64-bit word. The block round-robin arbitrates between the requesters, then feeds the transmitter one byte at a time, LSB byte first, using a level request/busy handshake. It runs on the fast system clock. The transmitter runs on the divided baud-domain clock, so the transmitter's busy status is synchronised inside this block.

Parameters:
MAX_BYTES, 8, maximum bytes per message; payload width is 8*MAX_BYTES.
GAP_CYCLES, 16, idle clk cycles inserted between consecutive bytes of a message (0 allowed).
ACK_TIMEOUT, 400000, clk cycles to wait for synchronised busy to rise before abort.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
req  in  2  per-requester message request (level)
payload0  in  64  requester 0 message, byte 0 in [7:0]
payload1  in  64  requester 1 message
len0  in  4  requester 0 byte count, 1..8
len1  in  4  requester 1 byte count
done  out  2  one-cycle pulse to the served requester on completion
abort  out  2  one-cycle pulse to the served requester on timeout
gnt  out  2  one-hot grant, held for the whole message
tx_data  out  8  byte presented to the transmitter
tx_start  out  1  level request to the transmitter
tx_busy  in  1  transmitter status (baud domain, asynchronous to clk)

Behaviour:
- Reset:
  - gnt=0, done=0, abort=0, tx_start=0, tx_data=8'h00.
  - State=IDLE; round-robin pointer=0 (requester 0 has priority).
  - Busy synchroniser flops cleared.
- tx_busy passes through a 2-flop synchroniser. All logic uses the synchronised value bsy and its registered copy for edge detection.
- State machine:
  - IDLE: if any req is high, grant one requester.
    - With both requesting, grant the requester the pointer selects.
    - The pointer flips to the other requester after each grant.
    - Latch that requester's payload and length into internal registers. The requester may change its inputs after the grant.
    - len 0 is treated as 1. len >8 is treated as 8.
    - Set gnt one-hot, byte index=0, go to LOAD.
  - LOAD: tx_data=payload byte[index]. Assert tx_start. Clear the timeout counter. Go to WAIT_ACK.
  - WAIT_ACK: hold tx_start and tx_data stable.
    - On bsy rising edge: drop tx_start, go to WAIT_DONE.
    - If the timeout counter reaches ACK_TIMEOUT-1: drop tx_start, pulse abort for the granted requester, clear gnt, go to IDLE.
  - WAIT_DONE: on bsy falling edge, increment the index.
    - If index==len: pulse done for the granted requester, clear gnt, go to IDLE.
    - Else go to GAP.
  - GAP: count GAP_CYCLES cycles, then go to LOAD. With GAP_CYCLES=0, go straight to LOAD on the next cycle.
- done and abort are single-cycle pulses and never assert together.
- gnt stays high from the grant cycle until the cycle of the done/abort pulse. It is low in that pulse cycle and in the following cycle.
- A requester dropping req mid-message does not affect the message in progress. The message always completes or times out.
- A requester holding req after done is re-granted only if the other requester is not also requesting (round-robin).
- Minimum latency from req high in IDLE to tx_start high: 2 clk cycles (grant cycle plus LOAD).
- bsy already high on entry to WAIT_ACK does not count as acknowledgement; only a rising edge does.
- Asynchronous reset mid-message: all outputs return to reset values immediately. No done or abort pulse is produced.

Decomposition:
- Package uart_pkg holds:
  - the state enum {IDLE, LOAD, WAIT_ACK, WAIT_DONE, GAP};
  - the constants BYTE_W=8 and MAX_BYTES;
  - a function for length clamping.
- One natural sub-module, sync_2ff: a 1-bit two-flop synchroniser with asynchronous active-high reset to 0. It is instantiated for tx_busy.

Test Plan:
- Single-byte send. Stimulus: req0, len0=1, payload0=64'h85. Required response:
  - tx_data=8'h85 with tx_start high until bsy rises;
  - done[0] pulses one cycle after bsy falls;
  - gnt returns to 0.
- Multi-byte order. Stimulus: len0=4, payload0=64'h11563412. Required response:
  - bytes 8'h12, 34, 56, 11 sent in order;
  - at least GAP_CYCLES cycles between the bsy fall and the next tx_start.
- Arbitration. Stimulus: req=2'b11 held continuously. Required response:
  - grants alternate 0,1,0,1;
  - each message completes whole with no byte interleaving.
- Timeout. Stimulus: tx_busy held 0, ACK_TIMEOUT=50. Required response:
  - abort[0] pulses 50 cycles after tx_start rises;
  - tx_start drops and the block returns to IDLE.
- Length clamp. Stimulus: len1=0 then len1=12. Required response: exactly 1 byte, then exactly 8 bytes transmitted.
- Reset mid-message. Stimulus: rst asserted while in WAIT_DONE. Required response:
  - gnt=0, tx_start=0, tx_data=0 asynchronously;
  - no done or abort pulse;
  - the next req restarts from byte 0 with requester 0 priority.
